// File: rtl/block_deserializer.sv
// Serial-to-parallel block collector with ping-pong banks for the DCT input side.
// Checks the idx/block_start/block_end sequence and resyncs on the next block_start.

module block_deserializer_lane #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              wsel,
  input  logic              rsel,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [1:0][DATA_W-1:0] bank;

  always_ff @(posedge clk) begin
    if (rst) bank <= '0;
    else if (we) bank[wsel] <= din;
  end

  assign dout = bank[rsel];
endmodule

module block_deserializer #(
  parameter int BLOCK_SIZE = 8,
  parameter int DATA_W     = 16,
  parameter int IDX_W      = $clog2(BLOCK_SIZE),
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic [IDX_W-1:0]             idx,
  input  logic                         block_start,
  input  logic                         block_end,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BLOCK_SIZE*DATA_W-1:0] out_block,
  output logic                         seq_err,
  output logic                         err_sticky,
  output logic [CNT_W-1:0]             blk_count
);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              start;
    logic              last;
  } smp_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

  smp_t                                 req;
  logic [1:0]                           bank_full, bank_full_nxt;
  logic                                 wr_bank, rd_bank;
  logic [IDX_W-1:0]                     exp_idx;
  logic                                 acc, is_last, r_start, r_seq, r_bad;
  logic                                 complete, drain, err_now;
  logic [BLOCK_SIZE-1:0]                lane_we;
  logic [BLOCK_SIZE-1:0][DATA_W-1:0]    lane_dout;

  assign req = '{data: in_data, idx: idx, start: block_start, last: block_end};

  assign in_ready  = !bank_full[wr_bank];
  assign out_valid = bank_full[rd_bank];
  assign out_block = lane_dout;

  always_comb begin
    acc      = in_valid && in_ready;
    is_last  = (req.idx == LAST_IDX);
    r_start  = acc && req.start && (req.idx == '0);
    // block_end must agree with the position; a stray or missing end is an error
    r_seq    = acc && !r_start && !req.start && (req.idx == exp_idx) && (req.last == is_last);
    r_bad    = acc && !r_start && !r_seq;
    complete = r_seq && is_last;
    drain    = out_valid && out_ready;
    err_now  = (r_start && (exp_idx != '0)) || r_bad;
    // completion and drain can never target the same bank (in_ready vs out_valid)
    bank_full_nxt = bank_full;
    if (complete) bank_full_nxt[wr_bank] = 1'b1;
    if (drain)    bank_full_nxt[rd_bank] = 1'b0;
  end

  for (genvar k = 0; k < BLOCK_SIZE; k++) begin : g_lane
    assign lane_we[k] = (r_start || r_seq) && (req.idx == IDX_W'(k));
    block_deserializer_lane #(.DATA_W(DATA_W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .we   (lane_we[k]),
      .wsel (wr_bank),
      .rsel (rd_bank),
      .din  (req.data),
      .dout (lane_dout[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full  <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      exp_idx    <= '0;
      seq_err    <= 1'b0;
      err_sticky <= 1'b0;
      blk_count  <= '0;
    end else begin
      bank_full  <= bank_full_nxt;
      seq_err    <= err_now;
      err_sticky <= err_sticky | err_now;
      if (r_start)    exp_idx <= IDX_W'(1);
      else if (r_seq) exp_idx <= complete ? '0 : exp_idx + IDX_W'(1);
      else if (r_bad) exp_idx <= '0;
      if (complete) begin
        wr_bank   <= ~wr_bank;
        blk_count <= blk_count + CNT_W'(1);
      end
      if (drain) rd_bank <= ~rd_bank;
    end
  end
endmodule

// File: tb/tb_block_deserializer.sv
// Directed bench for block_deserializer; blk_count narrowed to 4 bits so wrap is reachable.
module tb_block_deserializer;
  localparam int BS = 8, DW = 16, IW = 3, CW = 4;

  logic             clk = 0, rst = 1;
  logic             in_valid = 0, in_ready;
  logic [DW-1:0]    in_data = '0;
  logic [IW-1:0]    idx = '0;
  logic             block_start = 0, block_end = 0;
  logic             out_valid, out_ready = 0;
  logic [BS*DW-1:0] out_block;
  logic             seq_err, err_sticky;
  logic [CW-1:0]    blk_count;

  int errors = 0, checks = 0, sec = 0, sec0 = 0, stall = 0;
  logic [127:0] q[$];

  block_deserializer #(.BLOCK_SIZE(BS), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .idx(idx), .block_start(block_start), .block_end(block_end), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .seq_err(seq_err),
    .err_sticky(err_sticky), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) q.push_back(out_block);
    if (seq_err) sec++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] d, input int i, input logic bs, input logic be);
    in_valid = 1; in_data = d; idx = IW'(i); block_start = bs; block_end = be;
    step();
    in_valid = 0;
  endtask

  task automatic send_blk(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) send(base + 16'(i), i, i == 0, i == BS - 1);
  endtask

  function automatic logic [127:0] blk(input logic [15:0] base);
    logic [127:0] r = '0;
    for (int k = 0; k < BS; k++) r[k*16 +: 16] = base + 16'(k);
    return r;
  endfunction

  initial begin
    // reset state
    step(); step(); rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_block", out_block, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_count", blk_count, 0);

    // 1: single clean block, one-cycle out_valid
    out_ready = 1;
    send_blk(16'h0010, 7);
    chk("t1_no_early_valid", out_valid, 0);
    send(16'h0017, 7, 0, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_block", out_block, blk(16'h0010));
    chk("t1_count", blk_count, 1);
    step();
    chk("t1_valid_drop", out_valid, 0);
    chk("t1_q", q.size(), 1);
    chk("t1_q0", q[0], blk(16'h0010));
    chk("t1_no_err", sec, 0);
    q.delete();

    // 2: backpressure, both banks full, order preserved
    out_ready = 0;
    send_blk(16'h0020, BS);
    chk("t2_ready_one_full", in_ready, 1);
    send_blk(16'h0030, BS);
    chk("t2_ready_both_full", in_ready, 0);
    chk("t2_hold_A", out_block, blk(16'h0020));
    in_valid = 1; in_data = 16'h0040; idx = 0; block_start = 1; block_end = 0;
    step(); step();
    chk("t2_still_stalled", in_ready, 0);
    chk("t2_still_A", out_block, blk(16'h0020));
    chk("t2_count_AB", blk_count, 3);
    out_ready = 1; step(); out_ready = 0;
    chk("t2_ready_after_drain", in_ready, 1);
    chk("t2_shows_B", out_block, blk(16'h0030));
    send_blk(16'h0040, BS);
    chk("t2_B_held", out_block, blk(16'h0030));
    chk("t2_count_C", blk_count, 4);
    out_ready = 1; step(); step();
    chk("t2_q", q.size(), 3);
    chk("t2_qA", q[0], blk(16'h0020));
    chk("t2_qB", q[1], blk(16'h0030));
    chk("t2_qC", q[2], blk(16'h0040));
    chk("t2_no_err", sec, 0);
    q.delete();

    // 3: skipped idx
    send_blk(16'h0050, 3);
    send(16'h0054, 4, 0, 0);
    chk("t3_seq_err", seq_err, 1);
    chk("t3_sticky", err_sticky, 1);
    step();
    chk("t3_pulse_end", seq_err, 0);
    chk("t3_no_valid", q.size(), 0);
    send_blk(16'h0058, BS); step();
    chk("t3_err_once", sec, 1);
    chk("t3_count", blk_count, 5);
    chk("t3_q", q.size(), 1);
    chk("t3_q0", q[0], blk(16'h0058));
    q.delete();

    // 4: restart mid-block
    send_blk(16'h0060, 5);
    send(16'h0070, 0, 1, 0);
    chk("t4_seq_err", seq_err, 1);
    for (int i = 1; i < BS; i++) send(16'h0070 + 16'(i), i, 0, i == BS - 1);
    step();
    chk("t4_q", q.size(), 1);
    chk("t4_new_only", q[0], blk(16'h0070));
    chk("t4_count", blk_count, 6);
    q.delete();

    // 5a: early block_end
    send_blk(16'h0080, 6);
    send(16'h0086, 6, 0, 1);
    chk("t5_seq_err", seq_err, 1);
    step();
    chk("t5_dropped", q.size(), 0);
    sec0 = sec;
    send_blk(16'h0088, BS); step();
    chk("t5_exp_reset", sec, sec0);
    chk("t5_count", blk_count, 7);
    chk("t5_q0", q[0], blk(16'h0088));
    q.delete();

    // 5b: reset mid-block
    send_blk(16'h0090, 4);
    rst = 1; step(); rst = 0;
    chk("t5r_in_ready", in_ready, 1);
    chk("t5r_out_valid", out_valid, 0);
    chk("t5r_out_block", out_block, 0);
    chk("t5r_seq_err", seq_err, 0);
    chk("t5r_sticky", err_sticky, 0);
    chk("t5r_count", blk_count, 0);
    repeat (10) step();
    chk("t5r_never_out", q.size(), 0);

    // 6: back-to-back blocks, counter wrap at 2^CW
    sec0 = sec;
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < BS; i++) begin
        if (!in_ready) stall++;
        send(16'(b * 16'h0100 + i), i, i == 0, i == BS - 1);
      end
      if (b == 14) chk("t6_count15m", blk_count, 15);
    end
    step();
    chk("t6_wrap", blk_count, 0);
    chk("t6_drains", q.size(), 16);
    chk("t6_q0", q[0], blk(16'h0000));
    chk("t6_q15", q[15], blk(16'h0F00));
    chk("t6_no_stall", stall, 0);
    chk("t6_no_err", sec, sec0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
